// File: rtl/cpu_tick_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_tick_ctrl
//  Purpose  : CPU clock-enable generator (halt / run / single-step / burst-N)
//             with debounced step button, heartbeat LED and tick counter.
//             The tick counter is built only when CPU_TICK_CNT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_tick_ctrl #(
    parameter int DIV       = 50_000_000,
    parameter int DB_CYCLES = 500_000,
    parameter int BURST_W   = 8,
    parameter int CNT_W     = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode_i,
    input  logic               step_btn_i,
    input  logic [BURST_W-1:0] burst_len_i,
    output logic               tick_o,
    output logic               heartbeat_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   tick_cnt_o
);

    localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int DB_W  = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(DIV - 1);
    localparam logic [DB_W-1:0]  c_db_last  = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BURST = 2'b11
    } state_t;

    // Button synchroniser and debouncer
    logic              r_s1;
    logic              r_s2;
    logic              r_db_lvl;
    logic              r_db_prev;
    logic [DB_W-1:0]   r_db_cnt;
    logic              w_press;

    // Tick FSM
    state_t            r_state;
    state_t            w_mode;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [BURST_W-1:0] r_rem;
    logic              r_busy;
    logic              r_tick;
    logic              r_hb;
    logic              w_fire;
    logic              w_div_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_db_lvl  <= 1'b0;
            r_db_prev <= 1'b0;
            r_db_cnt  <= '0;
        end else begin
            r_s1      <= step_btn_i;
            r_s2      <= r_s1;
            r_db_prev <= r_db_lvl;
            if (r_s2 != r_db_lvl) begin
                if (r_db_cnt == c_db_last) begin
                    r_db_lvl <= r_s2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_press    = r_db_lvl & ~r_db_prev;
    assign w_mode     = state_t'(mode_i);
    assign w_div_wrap = (r_div_cnt == c_div_last);

    // A tick is suppressed on the edge where the mode switch is taken.
    always_comb begin
        w_fire = 1'b0;
        if (w_mode == r_state) begin
            case (r_state)
                S_RUN:   w_fire = w_div_wrap;
                S_STEP:  w_fire = w_press;
                S_BURST: w_fire = (r_rem != '0) && w_div_wrap;
                default: w_fire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_HALT;
            r_div_cnt <= '0;
            r_rem     <= '0;
            r_busy    <= 1'b0;
            r_tick    <= 1'b0;
            r_hb      <= 1'b0;
        end else begin
            r_tick <= w_fire;
            r_hb   <= r_hb ^ w_fire;
            if (w_mode != r_state) begin
                r_state   <= w_mode;
                r_div_cnt <= '0;
                r_rem     <= '0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
                    end
                    S_BURST: begin
                        if (r_rem == '0) begin
                            r_div_cnt <= '0;
                            if (w_press) begin
                                r_rem  <= burst_len_i;
                                r_busy <= |burst_len_i;
                            end
                        end else if (w_div_wrap) begin
                            // busy drops together with the final tick
                            r_div_cnt <= '0;
                            r_rem     <= r_rem - BURST_W'(1);
                            r_busy    <= (r_rem != BURST_W'(1));
                        end else begin
                            r_div_cnt <= r_div_cnt + DIV_W'(1);
                        end
                    end
                    default: begin
                        r_div_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign tick_o      = r_tick;
    assign heartbeat_o = r_hb;
    assign busy_o      = r_busy;

`ifdef CPU_TICK_CNT_EN
    logic [CNT_W-1:0] r_tick_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_fire) begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

    assign tick_cnt_o = r_tick_cnt;
`else
    assign tick_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_tick_ctrl.sv
`default_nettype none
// Testbench for cpu_tick_ctrl: directed steps, expected tick edges queued
// as stimulus is driven and popped when the DUT is due to tick.
module tb_cpu_tick_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  mode;
    logic        btn;
    logic [7:0]  blen;
    logic        tick_o;
    logic        heartbeat_o;
    logic        busy_o;
    logic [23:0] tick_cnt_o;

    cpu_tick_ctrl #(
        .DIV       (4),
        .DB_CYCLES (4),
        .BURST_W   (8),
        .CNT_W     (24)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_i      (mode),
        .step_btn_i  (btn),
        .burst_len_i (blen),
        .tick_o      (tick_o),
        .heartbeat_o (heartbeat_o),
        .busy_o      (busy_o),
        .tick_cnt_o  (tick_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    int          en;
    int          bl;
    int          bh;
    int          base;
    int          exp_q[$];
    logic        exp_hb;
    logic [23:0] exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, en, obs, exp);
        end
    endtask

    // One clock edge, then compare every output against the model.
    task automatic step();
        logic rst_s;
        logic exp_t;
        rst_s = reset;
        @(posedge clk);
        #1;
        en++;
        if (rst_s) begin
            exp_hb  = 1'b0;
            exp_cnt = '0;
            bl      = 0;
            bh      = 0;
            exp_q.delete();
        end
        exp_t = 1'b0;
        if (exp_q.size() > 0 && exp_q[0] == en) begin
            exp_t = 1'b1;
            void'(exp_q.pop_front());
        end
        if (exp_t) begin
            exp_hb  = ~exp_hb;
            exp_cnt = exp_cnt + 24'd1;
        end
        chk("tick", 32'(tick_o), 32'(exp_t));
        chk("heartbeat", 32'(heartbeat_o), 32'(exp_hb));
        chk("busy", 32'(busy_o), 32'(en >= bl && en < bh));
`ifdef CPU_TICK_CNT_EN
        chk("tick_cnt", 32'(tick_cnt_o), 32'(exp_cnt));
`else
        chk("tick_cnt_off", 32'(tick_cnt_o), 32'd0);
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_press(input int hold);
        btn = 1'b1;
        run(hold);
        btn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; en = 0; bl = 0; bh = 0;
        exp_hb = 1'b0; exp_cnt = '0;
        reset = 1'b1; mode = 2'b01; btn = 1'b0; blen = 8'd0;

        // Reset held two edges in RUN mode, then free-run at DIV=4
        run(2);
        reset = 1'b0;
        exp_q.push_back(en + 5);
        exp_q.push_back(en + 9);
        exp_q.push_back(en + 13);
        run(14);
        mode = 2'b00;
        run(8);

        // Single step with held button, then a short glitch
        mode = 2'b10;
        run(3);
        base = en;
        exp_q.push_back(base + 7);
        btn = 1'b1;
        run(12);
        btn = 1'b0;
        run(12);
        btn = 1'b1;
        run(2);
        btn = 1'b0;
        run(12);

        // Burst of 3 with a second press landing mid-burst
        mode = 2'b11;
        blen = 8'd3;
        run(3);
        base = en;
        exp_q.push_back(base + 11);
        exp_q.push_back(base + 15);
        exp_q.push_back(base + 19);
        bl = base + 7;
        bh = base + 19;
        do_press(6);
        run(6);
        do_press(6);
        run(22);

        // Zero-length burst
        blen = 8'd0;
        do_press(6);
        run(20);

        // Burst of 5 aborted by switching to HALT after two ticks
        blen = 8'd5;
        base = en;
        exp_q.push_back(base + 11);
        exp_q.push_back(base + 15);
        bl = base + 7;
        bh = base + 17;
        do_press(6);
        run(10);
        mode = 2'b00;
        run(20);

`ifdef CPU_TICK_CNT_EN
        // Counter wrap from all-ones
        mode = 2'b10;
        run(3);
        force dut.r_tick_cnt = 24'hFFFFFF;
        #1;
        release dut.r_tick_cnt;
        exp_cnt = 24'hFFFFFF;
        run(1);
        chk("cnt_preset", 32'(tick_cnt_o), 32'h00FFFFFF);
        base = en;
        exp_q.push_back(base + 7);
        do_press(6);
        run(14);
        chk("cnt_wrapped", 32'(tick_cnt_o), 32'd0);
`endif

        // Reset during a burst with the button held through release
        mode = 2'b11;
        blen = 8'd5;
        run(3);
        base = en;
        exp_q.push_back(base + 11);
        bl = base + 7;
        bh = base + 14;
        do_press(6);
        run(6);
        btn = 1'b1;
        run(1);
        reset = 1'b1;
        run(2);
        blen = 8'd1;
        reset = 1'b0;
        base = en;
        exp_q.push_back(base + 11);
        bl = base + 7;
        bh = base + 11;
        run(14);
        btn = 1'b0;
        run(14);

        chk("pending_ticks", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
